// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Memory read channel between the LC-3 instruction-fetch sequencer and the
//   instruction memory. One read transaction is open for as long as mem_rd is
//   high. The memory completes it by raising mem_ready for one cycle, with
//   mem_rdata valid in that same cycle.
//
//   Signals
//     mem_addr   fetch -> mem   read address (the fetch unit's MAR)
//     mem_rd     fetch -> mem   read request, held high while waiting
//     mem_rdata  mem -> fetch   read data, valid while mem_ready==1
//     mem_ready  mem -> fetch   data-valid strobe
//
//   Modports
//     master  fetch-unit side (drives address and request)
//     slave   memory side (drives data and ready)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] mem_addr;
    logic             mem_rd;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ready
    );
endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   LC-3 instruction-fetch sequencer, the stage directly upstream of IR.
//   A fetch runs MAR<-PC (with a PC increment pulse), then reads M[MAR] into
//   MDR through a wait-state handshake, then drives MDR onto Buss while
//   asserting ldIR so IR captures the instruction at the following edge.
//   A read that waits TIMEOUT cycles without mem_ready ends in ERR, which
//   holds until the control FSM retries with start_fetch.
//
//   Parameters
//     WIDTH    data/address width (Buss, PC, MAR, MDR)
//     TIMEOUT  READ cycles allowed before a timeout (>= 1)
//     TO_W     timeout counter width, 2**TO_W > TIMEOUT
//
//   Ports
//     clk          system clock, rising edge
//     reset        asynchronous active-low reset
//     start_fetch  fetch request, honoured only in IDLE and ERR
//     PC           program counter, sampled only at the end of ADDR
//     ldPC_inc     one-cycle pulse: PC register increments
//     mem          memory read channel (master side)
//     Buss         MDR while gateMDR==1, otherwise 0
//     gateMDR      this block owns Buss this cycle
//     ldIR         IR load enable, IR latches Buss at the next edge
//     fetch_busy   high in ADDR, READ and LATCH
//     fetch_done   one-cycle pulse after a successful IR load
//     fetch_err    high while in ERR (memory timeout)
//
//   Every output comes from a register or from state, so nothing on the
//   input side reaches an output in the same cycle.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_fetch,
    input  logic [WIDTH-1:0] PC,
    output logic             ldPC_inc,
    fetch_unit_if.master     mem,
    output logic [WIDTH-1:0] Buss,
    output logic             gateMDR,
    output logic             ldIR,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        LATCH,
        DONE,
        ERR
    } state_t;

    // Per-state output flags. They are loaded together with the state, so
    // each output is a plain flop.
    typedef struct packed {
        logic ld_pc_inc;
        logic mem_rd;
        logic gate_mdr;
        logic ld_ir;
        logic busy;
        logic done;
        logic err;
    } flags_t;

    state_t           state;
    flags_t           flags;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] mdr;
    logic [TO_W-1:0]  to_cnt;

    // Output values that belong to a state. Called with the state being
    // entered, so the flags are ready on the first cycle of that state.
    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            ADDR: begin
                f.ld_pc_inc = 1'b1;
                f.busy      = 1'b1;
            end
            READ: begin
                f.mem_rd = 1'b1;
                f.busy   = 1'b1;
            end
            LATCH: begin
                f.gate_mdr = 1'b1;
                f.ld_ir    = 1'b1;
                f.busy     = 1'b1;
            end
            DONE:    f.done = 1'b1;
            ERR:     f.err  = 1'b1;
            default: f      = '0;
        endcase
        return f;
    endfunction

    // The last READ cycle before a timeout is the one where the counter has
    // already counted TIMEOUT-1 idle cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others; blocking updates
    // would make the result depend on statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // MDR is a single register, not a memory array, so it is reset
            // along with everything else; Buss must read 0 out of reset.
            state  <= IDLE;
            flags  <= '0;
            mar    <= '0;
            mdr    <= '0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fetch) begin
                        state <= ADDR;
                        flags <= flags_for(ADDR);
                    end
                end

                ADDR: begin
                    mar    <= PC;
                    to_cnt <= '0;
                    state  <= READ;
                    flags  <= flags_for(READ);
                end

                READ: begin
                    // A ready strobe on the timeout cycle still completes.
                    if (mem.mem_ready) begin
                        mdr   <= mem.mem_rdata;
                        state <= LATCH;
                        flags <= flags_for(LATCH);
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERR;
                        flags <= flags_for(ERR);
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                LATCH: begin
                    state <= DONE;
                    flags <= flags_for(DONE);
                end

                // start_fetch is deliberately not looked at here; the control
                // FSM gets one idle cycle before a new fetch can begin.
                DONE: begin
                    state <= IDLE;
                    flags <= flags_for(IDLE);
                end

                ERR: begin
                    if (start_fetch) begin
                        state <= ADDR;
                        flags <= flags_for(ADDR);
                    end
                end

                default: begin
                    state <= IDLE;
                    flags <= flags_for(IDLE);
                end
            endcase
        end
    end

    // MAR stays on the address lines in every state.
    assign mem.mem_addr = mar;
    assign mem.mem_rd   = flags.mem_rd;

    assign ldPC_inc   = flags.ld_pc_inc;
    assign gateMDR    = flags.gate_mdr;
    assign Buss       = flags.gate_mdr ? mdr : '0;
    assign ldIR       = flags.ld_ir;
    assign fetch_busy = flags.busy;
    assign fetch_done = flags.done;
    assign fetch_err  = flags.err;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Transaction-level model of the fetch sequencer. Each accepted start is
//   turned into an expected fetch record (address, data, wait count, success
//   or timeout, start edge) pushed into a queue. A monitor on the falling edge
//   pops a record whenever the DUT shows ldIR, fetch_done or a new fetch_err
//   and compares timing and values against it.
//
//   Edge numbering: cyc holds the index of the most recent rising edge. A
//   start sampled at edge t with w wait states gives ldIR after edge t+2+w,
//   fetch_done after t+3+w, and a timeout gives fetch_err after t+1+TIMEOUT.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          w;
        bit          ok;
        int          t;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_fetch = 1'b0;
    logic [15:0] PC = '0;
    logic        ldPC_inc;
    logic [15:0] Buss;
    logic        gateMDR;
    logic        ldIR;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;

    fetch_unit_if #(.WIDTH(WIDTH)) mem_bus ();

    fetch_unit #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_fetch(start_fetch),
        .PC         (PC),
        .ldPC_inc   (ldPC_inc),
        .mem        (mem_bus.master),
        .Buss       (Buss),
        .gateMDR    (gateMDR),
        .ldIR       (ldIR),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t exp_q[$];

    // Environment state: architectural PC register and memory image.
    logic [15:0] pc = 16'h0;
    logic [15:0] img [logic [15:0]];
    int          cur_wait = 0;
    int          rd_idx = 0;
    int          next_accept = 0;
    int          last_t = -10;
    bit          inc_pending = 1'b0;
    bit          in_reset_test = 1'b0;

    // Monitor bookkeeping.
    int   inc_cnt = 0;
    int   rd_cnt = 0;
    bit   err_seen = 1'b0;
    txn_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (img.exists(a)) return img[a];
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // One clock of environment: apply the PC increment, answer the memory,
    // and offer start_fetch for the next edge. A start the model says will
    // be accepted produces an expected record.
    task automatic step(input bit start, input int w, input bit jump);
        bit rdy;
        @(posedge clk);
        #1;
        if (inc_pending) begin
            pc          = pc + 16'd1;
            inc_pending = 1'b0;
        end
        if (mem_bus.mem_rd) begin
            rd_idx++;
            rdy                = (rd_idx > cur_wait);
            mem_bus.mem_ready  = rdy;
            mem_bus.mem_rdata  = rdy ? mem_word(mem_bus.mem_addr) : 16'($urandom);
        end else begin
            rd_idx             = 0;
            mem_bus.mem_ready  = 1'($urandom);
            mem_bus.mem_rdata  = 16'($urandom);
        end
        start_fetch = start;
        if (start && (cyc + 1 >= next_accept)) begin
            txn_t e;
            if (jump) pc = 16'($urandom);
            cur_wait = w;
            e.addr   = pc;
            e.data   = mem_word(pc);
            e.w      = w;
            e.ok     = (w < TIMEOUT);
            e.t      = cyc + 1;
            exp_q.push_back(e);
            last_t      = e.t;
            next_accept = e.ok ? e.t + 5 + w : e.t + 2 + TIMEOUT;
        end
        // PC only matters on the edge that ends ADDR; any other value is junk.
        PC = (cyc == last_t) ? pc : 16'($urandom);
    endtask

    function automatic int deadline(input txn_t e);
        return e.ok ? e.t + 3 + e.w : e.t + 1 + TIMEOUT;
    endfunction

    always @(negedge clk) begin
        if (reset && !in_reset_test) begin
            if (ldPC_inc) begin
                inc_cnt++;
                inc_pending = 1'b1;
            end
            if (mem_bus.mem_rd) rd_cnt++;
            if (!gateMDR) check("buss_zero_when_not_gated", 32'(Buss), 32'h0);

            if (ldIR) begin
                if (exp_q.size() == 0) begin
                    check("ldir_unexpected", 32'(ldIR), 32'h0);
                end else begin
                    mon_e = exp_q[0];
                    check("ldir_cycle", cyc, mon_e.ok ? mon_e.t + 2 + mon_e.w : -1);
                    check("ldir_buss", 32'(Buss), 32'(mon_e.data));
                    check("ldir_gate", 32'(gateMDR), 32'h1);
                    check("ldir_addr", 32'(mem_bus.mem_addr), 32'(mon_e.addr));
                    check("ldir_busy", 32'(fetch_busy), 32'h1);
                    check("ldir_read_cycles", rd_cnt, mon_e.w + 1);
                end
            end

            if (fetch_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(fetch_done), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_cycle", cyc, mon_e.ok ? mon_e.t + 3 + mon_e.w : -1);
                    check("done_pc_inc_count", inc_cnt, 1);
                    check("done_busy", 32'(fetch_busy), 32'h0);
                end
                inc_cnt = 0;
                rd_cnt  = 0;
            end

            if (fetch_err && !err_seen) begin
                err_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("err_unexpected", 32'(fetch_err), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_cycle", cyc, mon_e.ok ? -1 : mon_e.t + 1 + TIMEOUT);
                    check("err_read_cycles", rd_cnt, TIMEOUT);
                    check("err_pc_inc_count", inc_cnt, 1);
                end
                inc_cnt = 0;
                rd_cnt  = 0;
            end
            if (!fetch_err) err_seen = 1'b0;

            if (exp_q.size() != 0 && cyc > deadline(exp_q[0])) begin
                mon_e = exp_q.pop_front();
                check("fetch_overdue", cyc, deadline(mon_e));
                inc_cnt = 0;
                rd_cnt  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;

        // Reset state.
        #12;
        check("reset_outputs",
              {16'h0, ldPC_inc, mem_bus.mem_rd, gateMDR, ldIR, fetch_busy, fetch_done, fetch_err, 9'h0},
              32'h0);
        check("reset_buss_addr", {Buss, mem_bus.mem_addr}, 32'h0);
        #6 reset = 1'b1;

        // Zero-wait fetch at 3000.
        img[16'h3000] = 16'h1261;
        pc = 16'h3000;
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // Five wait states.
        step(1, 5, 0);
        repeat (11) step(0, 0, 0);

        // Timeout, linger in ERR, retry from ERR, then a normal fetch.
        step(1, 20, 0);
        repeat (TIMEOUT + 5) step(0, 0, 0);
        step(1, 2, 0);
        repeat (8) step(0, 0, 0);

        // Ready on the last allowed READ cycle.
        step(1, TIMEOUT - 1, 0);
        repeat (TIMEOUT + 6) step(0, 0, 0);

        // Async reset in the middle of READ.
        step(1, 6, 0);
        repeat (3) step(0, 0, 0);
        @(posedge clk);
        #3;
        in_reset_test = 1'b1;
        reset = 1'b0;
        #1;
        check("async_rst_mem_rd", 32'(mem_bus.mem_rd), 32'h0);
        check("async_rst_busy", 32'(fetch_busy), 32'h0);
        check("async_rst_buss", 32'(Buss), 32'h0);
        exp_q.delete();
        next_accept = 0;
        rd_idx      = 0;
        inc_pending = 1'b0;
        inc_cnt     = 0;
        rd_cnt      = 0;
        err_seen    = 1'b0;
        start_fetch = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        in_reset_test = 1'b0;
        step(1, 1, 0);
        repeat (7) step(0, 0, 0);

        // start_fetch held high: back-to-back fetches.
        repeat (40) step(1, $urandom_range(3), 0);
        repeat (8) step(0, 0, 0);

        // Randomized traffic, including timeouts and PC jumps.
        repeat (400) step($urandom_range(2) == 0, $urandom_range(10), $urandom_range(3) == 0);

        // Drain.
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
